wb_arbiter: RTL

Write-back arbiter that merges register-write requests from the execution units (ALU, LSU, MDU) into the single write port of the 32×64 integer register file. Accepts at most one request per cycle through per-source valid/ready handshakes, registers it, and drives the register file's waddr/wen/wdata one cycle later. Sits between the execute/memory stages and the register file, and also provides a retired-write counter for the difftest harness.

---
 rtl/wb_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 60 ++++++
 rtl/wb_arbiter.sv | 63 ++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back arbiter.
// Sources: 0 = ALU, 1 = LSU, 2 = MDU.
package wb_pkg;

  localparam int NSRC    = 3;
  localparam int XLEN    = 64;
  localparam int SRC_ALU = 0;
  localparam int SRC_LSU = 1;
  localparam int SRC_MDU = 2;

  typedef logic [$clog2(NSRC)-1:0] src_idx_t;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  function automatic src_idx_t next_idx(src_idx_t i);
    if (i == src_idx_t'(NSRC - 1))
      return '0;
    return src_idx_t'(i + 1'b1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Grant selector for the write-back port.
// WB_RR_EN selects rotating priority; otherwise fixed, lowest index first.
module rr_arbiter
  import wb_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [NSRC-1:0] req,
  input  logic            take,
  output logic [NSRC-1:0] gnt,
  output src_idx_t        gnt_idx
);

`ifdef WB_RR_EN

  src_idx_t ptr;
  src_idx_t idx;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      ptr <= '0;
    else if (take)
      ptr <= next_idx(gnt_idx);
  end

  // Scan farthest-from-ptr first so the nearest requester wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = ptr;
    for (int k = NSRC - 1; k >= 0; k--) begin
      idx = src_idx_t'((int'(ptr) + k) % NSRC);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

`else

  logic unused_ok;
  assign unused_ok = ^{clock, reset, take};

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (req[k]) begin
        gnt     = '0;
        gnt[k]  = 1'b1;
        gnt_idx = src_idx_t'(k);
      end
    end
  end

`endif

endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU/LSU/MDU write-backs into the single register-file write port.
// Define WB_RR_EN for round-robin priority; default is fixed priority.
module wb_arbiter
  import wb_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NSRC-1:0]      req_valid,
  input  logic [NSRC*5-1:0]    req_rd,
  input  logic [NSRC*XLEN-1:0] req_data,
  output logic [NSRC-1:0]      req_ready,
  output logic [4:0]           waddr,
  output logic                 wen,
  output logic [XLEN-1:0]      wdata,
  output logic [63:0]          wb_cnt
);

  logic [NSRC-1:0][4:0]      rd_a;
  logic [NSRC-1:0][XLEN-1:0] data_a;
  logic [NSRC-1:0]           gnt;
  src_idx_t                  gnt_idx;
  logic                      hs;
  wb_req_t                   sel;
  wb_req_t                   q;

  assign rd_a   = req_rd;
  assign data_a = req_data;

  rr_arbiter u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (req_valid),
    .take    (hs),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Nothing is accepted while reset is held.
  assign req_ready = gnt & {NSRC{reset}};
  assign hs        = |req_ready;

  assign sel.rd   = rd_a[gnt_idx];
  assign sel.data = data_a[gnt_idx];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q      <= '0;
      wen    <= 1'b0;
      wb_cnt <= '0;
    end else begin
      wen <= hs && (sel.rd != 5'd0);
      if (hs) begin
        q <= sel;
        if (sel.rd != 5'd0)
          wb_cnt <= wb_cnt + 64'd1;
      end
    end
  end

  assign waddr = q.rd;
  assign wdata = q.data;

endmodule
